mult_issue_ctrl: RTL and testbench
==================================

Name: mult_issue_ctrl

Overview:
Operand queue and issue controller for the 32-bit sequential signed multiplier. Accepts operand pairs on a valid/ready input stream and buffers them in a small FIFO. Issues one pair at a time to the multiplier with a start pulse, holds operands stable until done, and presents the 64-bit product on a valid/ready output stream. Carries a sequence tag and a watchdog timeout so a hung multiplier is detected.

Parameters:
N, 32, operand width; product width is 2N
DEPTH, 4, FIFO entries; power of 2, minimum 2
TAG_W, 4, sequence tag width
TIMEOUT, 40, maximum cycles in WAIT before abort; minimum 2

Ports:
clk  in  1  clock, all logic on rising edge
reset  in  1  synchronous, active-high
in_valid  in  1  operand pair valid
in_ready  out  1  FIFO not full
in_a  in  N  multiplicand, two's complement
in_b  in  N  multiplier, two's complement
res_valid  out  1  product valid
res_ready  in  1  downstream accepts product
res_data  out  2N  signed product
res_tag  out  TAG_W  tag of the operand pair that produced res_data
mul_start  out  1  one-cycle start pulse to multiplier
mul_a  out  N  operand A to multiplier, stable from ISSUE until WAIT exit
mul_b  out  N  operand B to multiplier, same stability rule
mul_done  in  1  multiplier completion pulse
mul_result  in  2N  multiplier product, valid while mul_done=1
busy  out  1  (state!=IDLE) or FIFO not empty
err  out  1  sticky timeout flag
err_clr  in  1  clears err
level  out  log2(DEPTH)+1  FIFO occupancy

Behaviour:
- Reset: synchronous, active-high; clock clk. Reset clears FIFO (level=0), state=IDLE, tag counter=0, err=0. Outputs after reset: in_ready=1, res_valid=0, res_data=0, res_tag=0, mul_start=0, mul_a=0, mul_b=0, busy=0. Reset mid-operation drops queued pairs and any in-flight result without emitting them.
- FIFO: in_ready = (level != DEPTH); no pass-through. Push when in_valid && in_ready; each entry stores {tag, in_a, in_b}, tag = tag counter value; tag counter increments per push and wraps mod 2^TAG_W. Simultaneous push and pop keep level unchanged. Pointers wrap mod DEPTH.
- FSM states: IDLE, ISSUE, WAIT, HOLD.
- IDLE: if level>0, pop head into mul_a/mul_b/cur_tag and go to ISSUE; otherwise stay.
- ISSUE: mul_start=1 for exactly this cycle; watchdog timer cleared to 0; next state WAIT.
- WAIT: timer increments each cycle. If mul_done=1, capture res_data=mul_result and res_tag=cur_tag, then go to HOLD. Else if timer==TIMEOUT-1, set err=1 and go to IDLE, discarding the pair. mul_done and timeout in the same cycle: done wins, err unchanged.
- HOLD: res_valid=1, with res_data and res_tag stable; when res_ready=1, go to IDLE with res_valid=0 next cycle. res_ready while not in HOLD is ignored.
- mul_done outside WAIT is ignored.
- Latency: a pair pushed at edge t into an empty, idle block gives state ISSUE after edge t+1 (mul_start high in cycle t+1..t+2). res_valid rises at the edge after mul_done is sampled. Minimum back-to-back issue spacing: one IDLE cycle after the HOLD handshake.
- err_clr=1 clears err; a timeout in the same cycle sets err (set wins).
- Products are passed through unmodified; sign handling is the multiplier's responsibility.
- Results are emitted strictly in push order; res_tag increments by 1 mod 2^TAG_W between emitted results unless a timeout dropped one.

Test Plan:
- Single op: push a=7, b=-3; multiplier model pulses done 33 cycles after start with -21 -> mul_start is a single-cycle pulse; res_data=0xFFFFFFFFFFFFFFEB, res_tag=0, res_valid held until res_ready.
- Fill: push 5 pairs back-to-back with DEPTH=4 and the multiplier stalled -> in_ready=0 once level=4 (one pair already popped into ISSUE); no entry lost; products emerge in order with tags 0..4.
- Backpressure: res_ready=0 for 10 cycles in HOLD -> res_data/res_tag stable, no new mul_start, FIFO keeps accepting until full.
- Timeout: model never asserts done -> err=1 exactly TIMEOUT cycles after WAIT entry; pair dropped; next pair issues; err_clr returns err to 0.
- Boundary values: pairs (0x80000000, 0x80000000), (0xFFFFFFFF, 1), (0, 0x7FFFFFFF) -> res_data equals model output exactly (0x4000000000000000, 0xFFFFFFFFFFFFFFFF, 0).
- Reset mid-WAIT with 2 pairs queued -> next cycle level=0, res_valid=0, busy=0; stray mul_done afterwards is ignored; tag restarts at 0.

Source files
------------

// File: rtl/mult_issue_if.sv
// ---------------------------------------------------------------------------
// mult_issue_if
// Handshake and multiplier-side bundle for mult_issue_ctrl.
//   in_*   : operand pair stream (valid/ready)
//   res_*  : product stream (valid/ready), carries the pair's sequence tag
//   mul_*  : sequential multiplier connection (start pulse, operands,
//            completion pulse and product)
// slave  : controller side.  master : environment side (source/sink/multiplier).
// ---------------------------------------------------------------------------
interface mult_issue_if #(
  parameter int N     = 32,
  parameter int TAG_W = 4
);
  logic               in_valid;
  logic               in_ready;
  logic [N-1:0]       in_a;
  logic [N-1:0]       in_b;
  logic               res_valid;
  logic               res_ready;
  logic [2*N-1:0]     res_data;
  logic [TAG_W-1:0]   res_tag;
  logic               mul_start;
  logic [N-1:0]       mul_a;
  logic [N-1:0]       mul_b;
  logic               mul_done;
  logic [2*N-1:0]     mul_result;

  modport slave (
    input  in_valid, in_a, in_b, res_ready, mul_done, mul_result,
    output in_ready, res_valid, res_data, res_tag, mul_start, mul_a, mul_b
  );

  modport master (
    output in_valid, in_a, in_b, res_ready, mul_done, mul_result,
    input  in_ready, res_valid, res_data, res_tag, mul_start, mul_a, mul_b
  );
endinterface

// File: rtl/mult_issue_ctrl.sv
// ---------------------------------------------------------------------------
// mult_issue_ctrl
// Operand queue and issue controller for a sequential signed multiplier.
// Operand pairs are buffered in a DEPTH-entry FIFO together with a sequence
// tag, issued one at a time with a single-cycle start pulse, and the product
// is held on the result stream until accepted. A watchdog aborts an issue
// whose multiplier never completes and raises a sticky error flag.
// Ports:
//   clk, reset  : clock, synchronous active-high reset
//   bus         : mult_issue_if.slave (operand, result and multiplier signals)
//   i_err_clr   : clears o_err (a timeout in the same cycle wins)
//   o_busy      : controller not idle or FIFO not empty
//   o_err       : sticky watchdog timeout flag
//   o_level     : FIFO occupancy
// ---------------------------------------------------------------------------
module mult_issue_ctrl #(
  parameter  int N       = 32,
  parameter  int DEPTH   = 4,
  parameter  int TAG_W   = 4,
  parameter  int TIMEOUT = 40,
  localparam int AW      = $clog2(DEPTH),
  localparam int TW      = $clog2(TIMEOUT)
) (
  input  logic          clk,
  input  logic          reset,
  mult_issue_if.slave   bus,
  input  logic          i_err_clr,
  output logic          o_busy,
  output logic          o_err,
  output logic [AW:0]   o_level
);

  localparam int EW = TAG_W + 2*N;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_HOLD} state_t;

  state_t             r_state, w_next;
  logic [EW-1:0]      r_mem [DEPTH];
  logic [AW-1:0]      r_wr_ptr, r_rd_ptr;
  logic [AW:0]        r_level;
  logic [TAG_W-1:0]   r_tag_cnt, r_cur_tag, r_res_tag;
  logic [N-1:0]       r_mul_a, r_mul_b;
  logic [2*N-1:0]     r_res_data;
  logic [TW-1:0]      r_timer;
  logic               r_err;
  logic               w_push, w_pop, w_start, w_capture, w_timeout;

  // No pass-through: a pair must land in the FIFO before it can issue.
  assign bus.in_ready = (r_level != (AW+1)'(DEPTH));
  assign w_push       = bus.in_valid && bus.in_ready;
  assign w_pop        = (r_state == S_IDLE) && (r_level != '0);

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next    = r_state;
    w_start   = 1'b0;
    w_capture = 1'b0;
    w_timeout = 1'b0;
    case (r_state)
      S_IDLE:  if (r_level != '0) w_next = S_ISSUE;
      S_ISSUE: begin
        w_start = 1'b1;
        w_next  = S_WAIT;
      end
      S_WAIT: begin
        // Completion beats the watchdog when both land on the same cycle.
        if (bus.mul_done) begin
          w_capture = 1'b1;
          w_next    = S_HOLD;
        end else if (r_timer == TW'(TIMEOUT-1)) begin
          w_timeout = 1'b1;
          w_next    = S_IDLE;
        end
      end
      S_HOLD:  if (bus.res_ready) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Storage is not reset; only entries between the pointers are ever read.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= {r_tag_cnt, bus.in_a, bus.in_b};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_level    <= '0;
      r_tag_cnt  <= '0;
      r_cur_tag  <= '0;
      r_res_tag  <= '0;
      r_mul_a    <= '0;
      r_mul_b    <= '0;
      r_res_data <= '0;
      r_timer    <= '0;
      r_err      <= 1'b0;
    end else begin
      if (w_push) begin
        r_wr_ptr  <= r_wr_ptr + AW'(1);
        r_tag_cnt <= r_tag_cnt + TAG_W'(1);
      end
      if (w_pop) begin
        {r_cur_tag, r_mul_a, r_mul_b} <= r_mem[r_rd_ptr];
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + (AW+1)'(1);
        2'b01:   r_level <= r_level - (AW+1)'(1);
        default: r_level <= r_level;
      endcase
      if (r_state == S_ISSUE)     r_timer <= '0;
      else if (r_state == S_WAIT) r_timer <= r_timer + TW'(1);
      if (w_capture) begin
        r_res_data <= bus.mul_result;
        r_res_tag  <= r_cur_tag;
      end
      if (w_timeout)      r_err <= 1'b1;
      else if (i_err_clr) r_err <= 1'b0;
    end
  end

  assign bus.mul_start = w_start;
  assign bus.mul_a     = r_mul_a;
  assign bus.mul_b     = r_mul_b;
  assign bus.res_valid = (r_state == S_HOLD);
  assign bus.res_data  = r_res_data;
  assign bus.res_tag   = r_res_tag;
  assign o_busy        = (r_state != S_IDLE) || (r_level != '0);
  assign o_err         = r_err;
  assign o_level       = r_level;

endmodule

// File: tb/tb_mult_issue_ctrl.sv
// ---------------------------------------------------------------------------
// tb_mult_issue_ctrl
// Directed scenarios followed by a randomized phase. A transaction-level
// model (queue of pending pairs, the pair in service, its phase and wait
// count) predicts every output each cycle; a multiplier stub answers
// mul_start after a chosen delay with the product of the presented operands.
// ---------------------------------------------------------------------------
module tb_mult_issue_ctrl;
  localparam int N = 32, DEPTH = 4, TAG_W = 4, TIMEOUT = 40;
  localparam int P_IDLE = 0, P_ISSUE = 1, P_WAIT = 2, P_HOLD = 3;

  typedef struct packed { logic [TAG_W-1:0] tag; logic [N-1:0] a; logic [N-1:0] b; } ent_t;
  typedef struct packed { logic [TAG_W-1:0] tag; logic [2*N-1:0] data; } res_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       err_clr = 1'b0;
  logic       busy, err;
  logic [2:0] level;

  mult_issue_if #(.N(N), .TAG_W(TAG_W)) bus();

  mult_issue_ctrl #(.N(N), .DEPTH(DEPTH), .TAG_W(TAG_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset), .bus(bus), .i_err_clr(err_clr),
    .o_busy(busy), .o_err(err), .o_level(level)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_fail = 0;

  // model state
  ent_t             mq[$];
  ent_t             mcur;
  int               mph = P_IDLE, mwcnt = 0;
  logic [63:0]      mres = '0;
  logic [TAG_W-1:0] mrtag = '0, mtagc = '0;
  logic             merr = 1'b0;

  res_t got_q[$];
  int   stub_cnt = 0, stub_delay = 0;
  bit   stub_rand = 0, stray_en = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] want);
    n_chk++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, want, $time);
    end
  endtask

  function automatic logic [63:0] sprod(input logic [31:0] a, input logic [31:0] b);
    return 64'(longint'($signed(a)) * longint'($signed(b)));
  endfunction

  task automatic model_update();
    bit do_push, to;
    if (reset) begin
      mq.delete(); mcur = '0; mph = P_IDLE; mwcnt = 0;
      mres = '0; mrtag = '0; mtagc = '0; merr = 1'b0;
    end else begin
      do_push = bus.in_valid && (mq.size() < DEPTH);
      to = 0;
      case (mph)
        P_IDLE:  if (mq.size() > 0) begin mcur = mq.pop_front(); mph = P_ISSUE; end
        P_ISSUE: begin mwcnt = 0; mph = P_WAIT; end
        P_WAIT: begin
          if (bus.mul_done) begin
            mres = sprod(mcur.a, mcur.b); mrtag = mcur.tag; mph = P_HOLD;
          end else if (mwcnt == TIMEOUT-1) begin
            to = 1; mph = P_IDLE;
          end else mwcnt++;
        end
        default: if (bus.res_ready) mph = P_IDLE;
      endcase
      if (err_clr) merr = 1'b0;
      if (to)      merr = 1'b1;
      if (do_push) begin
        mq.push_back({mtagc, bus.in_a, bus.in_b});
        mtagc = mtagc + 1'b1;
      end
    end
  endtask

  task automatic compare();
    chk("in_ready",  64'(bus.in_ready),  64'(mq.size() != DEPTH));
    chk("level",     64'(level),         64'(mq.size()));
    chk("res_valid", 64'(bus.res_valid), 64'(mph == P_HOLD));
    chk("res_data",  bus.res_data,       mres);
    chk("res_tag",   64'(bus.res_tag),   64'(mrtag));
    chk("mul_start", 64'(bus.mul_start), 64'(mph == P_ISSUE));
    chk("mul_a",     64'(bus.mul_a),     64'(mcur.a));
    chk("mul_b",     64'(bus.mul_b),     64'(mcur.b));
    chk("busy",      64'(busy),          64'(mph != P_IDLE || mq.size() != 0));
    chk("err",       64'(err),           64'(merr));
  endtask

  // Multiplier stand-in: answers a start after a delay with the real product.
  task automatic stub();
    int d, r;
    if (stub_cnt > 0) begin
      stub_cnt--;
      bus.mul_done = (stub_cnt == 0);
      if (stub_cnt == 0) bus.mul_result = sprod(bus.mul_a, bus.mul_b);
    end else bus.mul_done = 1'b0;
    // stray completions, only when nothing is waiting on the multiplier
    if (stray_en && !bus.mul_done && stub_cnt == 0 && mph != P_WAIT && $urandom_range(0, 7) == 0) begin
      bus.mul_done = 1'b1;
      bus.mul_result = {$urandom, $urandom};
    end
    if (bus.mul_start) begin
      d = stub_delay;
      if (stub_rand) begin
        r = $urandom_range(0, 9);
        d = (r == 0) ? 0 : (r == 1) ? TIMEOUT : (r == 2) ? TIMEOUT+1 : $urandom_range(1, 12);
      end
      stub_cnt = d;
    end
  endtask

  task automatic step();
    if (bus.res_valid === 1'b1 && bus.res_ready) got_q.push_back({bus.res_tag, bus.res_data});
    @(posedge clk);
    model_update();
    @(negedge clk);
    compare();
    stub();
  endtask

  task automatic push(input logic [31:0] a, input logic [31:0] b);
    bus.in_valid = 1'b1; bus.in_a = a; bus.in_b = b;
    step();
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    int k = 0;
    bus.in_valid = 1'b0; bus.res_ready = 1'b1;
    while (!(mph == P_IDLE && mq.size() == 0) && k < 3000) begin step(); k++; end
    chk("drain_bound", 64'(k < 3000), 64'd1);
  endtask

  task automatic chk_got(input string nm, input int idx, input logic [TAG_W-1:0] tag, input logic [63:0] data);
    if (idx < got_q.size()) begin
      chk({nm, "_tag"},  64'(got_q[idx].tag), 64'(tag));
      chk({nm, "_data"}, got_q[idx].data, data);
    end else chk({nm, "_present"}, 64'(got_q.size()), 64'(idx + 1));
  endtask

  function automatic logic [31:0] pickv();
    case ($urandom_range(0, 5))
      0: return 32'h8000_0000;
      1: return 32'hFFFF_FFFF;
      2: return 32'h0;
      3: return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int k, ns;
    bus.in_valid = 1'b0; bus.in_a = '0; bus.in_b = '0; bus.res_ready = 1'b0;
    bus.mul_done = 1'b0; bus.mul_result = '0;
    repeat (3) step();
    reset = 1'b0;
    step();
    chk("rst_level",    64'(level), 64'd0);
    chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
    chk("rst_busy",     64'(busy), 64'd0);
    chk("rst_res_data", bus.res_data, 64'd0);

    // single op 7 * -3, multiplier answers 33 cycles after start
    stub_delay = 33;
    push(32'd7, 32'hFFFF_FFFD);
    k = 0; ns = 0;
    while (bus.res_valid !== 1'b1 && k < 100) begin step(); ns += int'(bus.mul_start); k++; end
    chk("single_valid", 64'(bus.res_valid), 64'd1);
    chk("single_starts", 64'(ns), 64'd1);
    chk("single_data", bus.res_data, 64'hFFFF_FFFF_FFFF_FFEB);
    chk("single_tag", 64'(bus.res_tag), 64'd0);

    // backpressure: result held while the FIFO fills behind it
    bus.in_valid = 1'b1; bus.in_a = 32'd11; bus.in_b = 32'd2;
    repeat (10) begin
      step();
      chk("bp_data", bus.res_data, 64'hFFFF_FFFF_FFFF_FFEB);
      chk("bp_start", 64'(bus.mul_start), 64'd0);
    end
    bus.in_valid = 1'b0;
    chk("bp_level", 64'(level), 64'd4);
    chk("bp_in_ready", 64'(bus.in_ready), 64'd0);
    stub_delay = 5;
    drain();
    chk("bp_count", 64'(got_q.size()), 64'd5);
    chk_got("bp0", 0, 4'd0, 64'hFFFF_FFFF_FFFF_FFEB);
    for (int i = 1; i < 5; i++) chk_got("bp", i, 4'(i), 64'd22);

    // fill with a slow multiplier
    got_q.delete(); stub_delay = 35;
    for (int i = 0; i < 5; i++) begin
      bus.in_valid = 1'b1; bus.in_a = 32'(i + 1); bus.in_b = 32'(-(i + 1));
      step();
    end
    bus.in_valid = 1'b0;
    chk("fill_level", 64'(level), 64'd4);
    chk("fill_in_ready", 64'(bus.in_ready), 64'd0);
    drain();
    chk("fill_count", 64'(got_q.size()), 64'd5);
    for (int i = 0; i < 5; i++) chk_got("fill", i, 4'(5 + i), 64'(longint'(-(i + 1) * (i + 1))));

    // watchdog timeout
    got_q.delete(); stub_delay = 0;
    push(32'd3, 32'd4);
    k = 0;
    while (bus.mul_start !== 1'b1 && k < 10) begin step(); k++; end
    chk("to_start_seen", 64'(bus.mul_start), 64'd1);
    k = 0;
    while (err !== 1'b1 && k < 100) begin step(); k++; end
    chk("to_cycles", 64'(k), 64'(TIMEOUT + 1));
    stub_delay = 5;
    push(32'd6, 32'd7);
    drain();
    chk("to_count", 64'(got_q.size()), 64'd1);
    chk_got("to_next", 0, 4'd11, 64'd42);
    chk("to_err_held", 64'(err), 64'd1);
    err_clr = 1'b1; step(); err_clr = 1'b0;
    chk("to_err_clr", 64'(err), 64'd0);

    // boundary operand values
    got_q.delete(); stub_delay = 3;
    push(32'h8000_0000, 32'h8000_0000);
    push(32'hFFFF_FFFF, 32'd1);
    push(32'd0, 32'h7FFF_FFFF);
    drain();
    chk_got("bnd0", 0, 4'd12, 64'h4000_0000_0000_0000);
    chk_got("bnd1", 1, 4'd13, 64'hFFFF_FFFF_FFFF_FFFF);
    chk_got("bnd2", 2, 4'd14, 64'd0);

    // reset while waiting with two pairs queued
    got_q.delete(); stub_delay = 35;
    for (int i = 0; i < 3; i++) begin
      bus.in_valid = 1'b1; bus.in_a = 32'(100 + i); bus.in_b = 32'd3; step();
    end
    bus.in_valid = 1'b0; bus.res_ready = 1'b0;
    repeat (2) step();
    chk("mid_level", 64'(level), 64'd2);
    reset = 1'b1; step(); reset = 1'b0; stub_cnt = 0;
    chk("mr_level", 64'(level), 64'd0);
    chk("mr_res_valid", 64'(bus.res_valid), 64'd0);
    chk("mr_busy", 64'(busy), 64'd0);
    bus.mul_done = 1'b1; bus.mul_result = 64'h1234;
    step(); step();
    chk("mr_stray_valid", 64'(bus.res_valid), 64'd0);
    chk("mr_stray_busy", 64'(busy), 64'd0);
    stub_delay = 2;
    push(32'd9, 32'd9);
    drain();
    chk_got("mr_tag", 0, 4'd0, 64'd81);

    // randomized traffic
    stub_rand = 1; stray_en = 1;
    repeat (800) begin
      bus.in_valid = 1'($urandom_range(0, 1));
      bus.in_a = pickv(); bus.in_b = pickv();
      bus.res_ready = ($urandom_range(0, 3) != 0);
      err_clr = ($urandom_range(0, 15) == 0);
      step();
    end
    stub_rand = 0; stray_en = 0; stub_delay = 4; err_clr = 1'b0;
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
